axi4_s_write_subordinate: RTL and testbench
===========================================

# axi4_s_write_subordinate

AXI4 write-channel subordinate that terminates the bursts issued by `axi4_m_write_manager`, on the downstream side of its AW/W/B channels. It accepts one write transaction at a time and stores beats into an internal word-addressed memory. It returns a B response and exposes a combinational debug read port for checking memory contents. No read channel; no IDs; one outstanding transaction.

## Interface
- `ADDRESS_SIZE`, 32, AW address width.
- `DATA_SIZE`, 32, W data width; 32 or 64 only.
- `MEM_DEPTH`, 16, memory depth in words; power of two, ≥2.

- `aclk` input 1 — clock, all logic on rising edge.
- `areset` input 1 — one clock; reset is synchronous and active-high.
- `s_axi_awaddr` input ADDRESS_SIZE — burst start byte address.
- `s_axi_awlen` input 8 — beats minus one.
- `s_axi_awsize` input 3 — bytes per beat, log2.
- `s_axi_awburst` input 2 — 00 FIXED, 01 INCR, others unsupported.
- `s_axi_awvalid` input 1 / `s_axi_awready` output 1 — AW handshake.
- `s_axi_wdata` input DATA_SIZE — beat data.
- `s_axi_wstrb` input DATA_SIZE/8 — byte enables.
- `s_axi_wlast` input 1 — last beat marker.
- `s_axi_wvalid` input 1 / `s_axi_wready` output 1 — W handshake.
- `s_axi_bresp` output 2 — 00 OKAY, 10 SLVERR, 11 DECERR.
- `s_axi_bvalid` output 1 / `s_axi_bready` input 1 — B handshake.
- `dbg_addr` input log2(MEM_DEPTH) — debug word index.
- `dbg_data` output DATA_SIZE — memory word at `dbg_addr`, combinational.

## Operation
- States: StIdle → StData → StResp → StIdle. Outputs decoded from the registered state only.
  - StIdle: `awready`=1. On AW handshake, capture addr, len, size, and burst. Clear the beat counter and error flags. Go to StData.
  - StData: `wready`=1. Each W handshake is one beat and increments the beat counter. The beat at count==awlen ends the burst: go to StResp.
  - StResp: `bvalid`=1 with `bresp` held stable. On `bready`, go to StIdle.
- Word index = address >> log2(DATA_SIZE/8). Low address bits are ignored, so addresses are aligned down.
- INCR: word index +1 per beat. FIXED: index constant for the whole burst.
- Unsupported request: `awburst` ∈ {10,11} or `awsize` ≠ log2(DATA_SIZE/8).
  - Every beat of the burst is still accepted.
  - No memory writes occur.
  - Response is SLVERR.
- Range check: a beat with word index ≥ MEM_DEPTH is dropped (not written) and sets the DECERR flag. In-range beats of the same burst are written.
- wlast mismatch (asserted before count==awlen, or deasserted on the final beat) sets the SLVERR flag. Burst length is governed by `awlen`, never by `wlast`.
- Response priority: DECERR > SLVERR > OKAY.
- Write: memory word updated on the handshake edge; new value visible on `dbg_data` the next cycle.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `bresp`=00, all memory words 0, state StIdle.
- The first cycle after `areset` deasserts has `awready`=1.
- Minimum transaction:
  - AW handshake in cycle N.
  - `wready`=1 from N+1.
  - Single beat accepted in N+1.
  - `bvalid`=1 in N+2.
  - `awready`=1 in the cycle after the B handshake.
- `awready` and `wready` are never 1 in the same cycle. W beats arriving before the AW handshake wait; `wvalid` is ignored in StIdle.
- `bvalid` stays 1 until `bready`; `bready` already high gives a one-cycle response.
- `wvalid` gaps mid-burst: stay in StData, no counter change.
- Reset mid-operation: burst abandoned, no response issued, memory cleared, outputs to reset values.
- `awlen`=255: 256 beats, 8-bit counter compare; no overflow reliance.

## Configuration
- `AXI4_S_WRITE_WSTRB_EN` defined: only bytes with `wstrb[i]`=1 are written.
- Not defined: every accepted in-range beat writes the full word and `wstrb` is ignored. All other behaviour is identical in both builds.

## Test plan
- Single beat, addr 0x0, len 0, size 010, burst 00, data 0xFFFF_FFFF, strb 1111 (manager's default transaction) → `bresp`=00 at N+2, `dbg_data[0]`=0xFFFF_FFFF.
- INCR, addr 0x8, len 3, data 1,2,3,4 with a 2-cycle `wvalid` gap after beat 2 → words 2..5 = 1,2,3,4, OKAY.
- INCR, addr 0x38, len 3, MEM_DEPTH 16 → words 14,15 written, beats 3–4 dropped, DECERR.
- Burst 10 (WRAP), len 1 → 2 beats accepted, memory unchanged, SLVERR. Separately, `wlast` on beat 0 of len 1 → both beats written, SLVERR.
- Strobe 0101 on word 0 holding 0xFFFF_FFFF, data 0 → 0xFF00_FF00 with `AXI4_S_WRITE_WSTRB_EN`, 0x0000_0000 without.
- `bready` held 0 for 5 cycles, then `areset` pulsed mid-burst → `bvalid` holds stable until `bready`; the reset drops all outputs to 0, memory reads 0, and the next AW is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/axi4_s_write_subordinate_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write manager and a write subordinate.
interface axi4_s_write_subordinate_if #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32
) ();
  logic [ADDRESS_SIZE-1:0] s_axi_awaddr;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_SIZE-1:0]    s_axi_wdata;
  logic [DATA_SIZE/8-1:0]  s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;

  modport master (
    output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    output s_axi_bready
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready
  );
endinterface

// File: rtl/axi4_s_write_subordinate.sv
// AXI4 write subordinate: one burst at a time into a word-addressed memory, B response, debug port.
// Define AXI4_S_WRITE_WSTRB_EN to honour wstrb byte enables; otherwise whole words are written.
module axi4_s_write_subordinate #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned MEM_DEPTH    = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  axi4_s_write_subordinate_if.slave    axi,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_SIZE-1:0]         dbg_data
);

  localparam int unsigned StrbW   = DATA_SIZE / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_SIZE-1:0] MemDepthA = ADDRESS_SIZE'(MEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e state_q, state_d;

  logic [ADDRESS_SIZE-1:0] idx_q;
  logic [7:0]              len_q, cnt_q;
  logic                    fixed_q, unsup_q, decerr_q, slverr_q;
  logic                    aw_hs, w_hs, last_beat, in_range, do_write, aw_unsup;
  logic [1:0]              resp;
  logic [DATA_SIZE-1:0]    wr_word;
  logic [DATA_SIZE-1:0]    mem_q [MEM_DEPTH];

  // awready is also masked by areset so it reads 0 while reset is held.
  assign aw_hs     = axi.s_axi_awvalid & (state_q == StIdle) & ~areset;
  assign w_hs      = axi.s_axi_wvalid & (state_q == StData);
  assign last_beat = (cnt_q == len_q);
  assign in_range  = (idx_q < MemDepthA);
  assign do_write  = w_hs & in_range & ~unsup_q;
  assign aw_unsup  = axi.s_axi_awburst[1] | (axi.s_axi_awsize != 3'(AddrLsb));
  assign resp      = decerr_q ? 2'b11 : ((slverr_q | unsup_q) ? 2'b10 : 2'b00);

  always_ff @(posedge aclk) begin
    if (areset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    axi.s_axi_awready = 1'b0;
    axi.s_axi_wready  = 1'b0;
    axi.s_axi_bvalid  = 1'b0;
    axi.s_axi_bresp   = 2'b00;
    unique case (state_q)
      StIdle: begin
        axi.s_axi_awready = ~areset;
        if (aw_hs) state_d = StData;
      end
      StData: begin
        axi.s_axi_wready = 1'b1;
        if (w_hs && last_beat) state_d = StResp;
      end
      StResp: begin
        axi.s_axi_bvalid = 1'b1;
        axi.s_axi_bresp  = resp;
        if (axi.s_axi_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fixed_q  <= 1'b0;
      unsup_q  <= 1'b0;
      decerr_q <= 1'b0;
      slverr_q <= 1'b0;
    end else if (aw_hs) begin
      idx_q    <= axi.s_axi_awaddr >> AddrLsb;
      len_q    <= axi.s_axi_awlen;
      cnt_q    <= '0;
      fixed_q  <= (axi.s_axi_awburst == 2'b00);
      unsup_q  <= aw_unsup;
      decerr_q <= 1'b0;
      slverr_q <= 1'b0;
    end else if (w_hs) begin
      cnt_q <= cnt_q + 8'd1;
      if (!fixed_q) idx_q <= idx_q + 1'b1;
      // Unsupported bursts never touch memory, so they are not range-checked.
      if (!unsup_q && !in_range) decerr_q <= 1'b1;
      if (axi.s_axi_wlast != last_beat) slverr_q <= 1'b1;
    end
  end

`ifdef AXI4_S_WRITE_WSTRB_EN
  always_comb begin
    wr_word = mem_q[idx_q[IdxW-1:0]];
    for (int b = 0; b < StrbW; b++) begin
      if (axi.s_axi_wstrb[b]) wr_word[8*b +: 8] = axi.s_axi_wdata[8*b +: 8];
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^axi.s_axi_wstrb;
  assign wr_word      = axi.s_axi_wdata;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_write) begin
      mem_q[idx_q[IdxW-1:0]] <= wr_word;
    end
  end

  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_axi4_s_write_subordinate.sv
// Directed self-checking bench for axi4_s_write_subordinate (32-bit data, 16-word memory).
`timescale 1ns/1ps
module tb_axi4_s_write_subordinate;
  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb;
  bit          timed_out;
  logic [1:0]  r;

  axi4_s_write_subordinate_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) axi ();

  axi4_s_write_subordinate #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .MEM_DEPTH(16)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .axi      (axi),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awsize = 3'b010;
    axi.s_axi_awburst = 2'b01; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = 4'hF; axi.s_axi_wlast = 1'b0;
    axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b0;
  endtask

  // Drives one full transaction; waits are bounded and flag timed_out on expiry.
  task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int gap_at, input int gap_len,
                           input int bad_last, output logic [1:0] resp);
    int n;
    axi.s_axi_awaddr = addr; axi.s_axi_awlen = len; axi.s_axi_awsize = size;
    axi.s_axi_awburst = burst; axi.s_axi_awvalid = 1'b1;
    n = 0;
    while (axi.s_axi_awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) timed_out = 1'b1;
    tick();
    axi.s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == gap_at) repeat (gap_len) tick();
      axi.s_axi_wvalid = 1'b1;
      axi.s_axi_wdata  = beat_data[i];
      axi.s_axi_wstrb  = beat_strb;
      axi.s_axi_wlast  = ((i == int'(len)) != (i == bad_last));
      n = 0;
      while (axi.s_axi_wready !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) timed_out = 1'b1;
      tick();
      axi.s_axi_wvalid = 1'b0;
    end
    n = 0;
    while (axi.s_axi_bvalid !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) timed_out = 1'b1;
    resp = axi.s_axi_bresp;
    axi.s_axi_bready = 1'b1;
    tick();
    axi.s_axi_bready = 1'b0;
  endtask

  task automatic test_reset();
    logic bad;
    areset = 1'b1;
    idle_inputs();
    dbg_addr = '0;
    tick(); tick();
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_bresp} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got aw/w/b/resp=%b, want 00000",
               {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_bresp});
    end
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      dbg_addr = 4'(k); #1;
      if (dbg_data !== 32'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("FAIL reset_mem: got nonzero word, want all 0"); end
    tick();
    areset = 1'b0;
    #1;
    checks++;
    if (axi.s_axi_awready !== 1'b1) begin
      fails++; $display("FAIL reset_awready_first: got %b, want 1", axi.s_axi_awready);
    end
  endtask

  task automatic test_single();
    tick();
    axi.s_axi_awaddr = 32'h0; axi.s_axi_awlen = 8'd0; axi.s_axi_awsize = 3'b010;
    axi.s_axi_awburst = 2'b00; axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = 32'hFFFF_FFFF; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_wlast = 1'b1;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready} !== 2'b10) begin
      fails++; $display("FAIL single_idle: got awready/wready=%b, want 10",
                        {axi.s_axi_awready, axi.s_axi_wready});
    end
    tick();
    axi.s_axi_awvalid = 1'b0;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready} !== 2'b01) begin
      fails++; $display("FAIL single_n1: got awready/wready=%b, want 01",
                        {axi.s_axi_awready, axi.s_axi_wready});
    end
    tick();
    axi.s_axi_wvalid = 1'b0;
    dbg_addr = 4'd0;
    #1;
    checks++;
    if ({axi.s_axi_bvalid, axi.s_axi_bresp} !== 3'b100) begin
      fails++; $display("FAIL single_n2_resp: got bvalid/bresp=%b, want 100",
                        {axi.s_axi_bvalid, axi.s_axi_bresp});
    end
    checks++;
    if (dbg_data !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL single_word0: got %h, want ffffffff", dbg_data);
    end
    axi.s_axi_bready = 1'b1;
    tick();
    axi.s_axi_bready = 1'b0;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_bvalid} !== 2'b10) begin
      fails++; $display("FAIL single_after_b: got awready/bvalid=%b, want 10",
                        {axi.s_axi_awready, axi.s_axi_bvalid});
    end
  endtask

  task automatic test_incr_gap();
    logic [31:0] want [8] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0, 32'h0};
    timed_out = 1'b0;
    beat_strb = 4'hF;
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    run_burst(32'h8, 8'd3, 3'b010, 2'b01, 2, 2, -1, r);
    checks++;
    if (timed_out || r !== 2'b00) begin
      fails++; $display("FAIL incr_resp: got %b timeout=%0d, want 00", r, timed_out);
    end
    for (int k = 1; k < 8; k++) begin
      dbg_addr = 4'(k); #1;
      checks++;
      if (dbg_data !== want[k]) begin
        fails++; $display("FAIL incr_word%0d: got %h, want %h", k, dbg_data, want[k]);
      end
    end
  endtask

  task automatic test_decerr();
    timed_out = 1'b0;
    beat_strb = 4'hF;
    beat_data[0] = 32'hA; beat_data[1] = 32'hB; beat_data[2] = 32'hC; beat_data[3] = 32'hD;
    run_burst(32'h38, 8'd3, 3'b010, 2'b01, -1, 0, -1, r);
    checks++;
    if (timed_out || r !== 2'b11) begin
      fails++; $display("FAIL decerr_resp: got %b timeout=%0d, want 11", r, timed_out);
    end
    dbg_addr = 4'd14; #1; checks++;
    if (dbg_data !== 32'hA) begin fails++; $display("FAIL decerr_w14: got %h, want a", dbg_data); end
    dbg_addr = 4'd15; #1; checks++;
    if (dbg_data !== 32'hB) begin fails++; $display("FAIL decerr_w15: got %h, want b", dbg_data); end
    dbg_addr = 4'd0; #1; checks++;
    if (dbg_data !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL decerr_no_alias0: got %h, want ffffffff", dbg_data);
    end
    dbg_addr = 4'd1; #1; checks++;
    if (dbg_data !== 32'h0) begin fails++; $display("FAIL decerr_no_alias1: got %h, want 0", dbg_data); end
  endtask

  task automatic test_unsupported();
    timed_out = 1'b0;
    beat_strb = 4'hF;
    beat_data[0] = 32'h5; beat_data[1] = 32'h6;
    run_burst(32'h0, 8'd1, 3'b010, 2'b10, -1, 0, -1, r);
    checks++;
    if (timed_out || r !== 2'b10) begin
      fails++; $display("FAIL wrap_resp: got %b timeout=%0d, want 10", r, timed_out);
    end
    dbg_addr = 4'd0; #1; checks++;
    if (dbg_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL wrap_w0: got %h, want ffffffff", dbg_data); end
    dbg_addr = 4'd1; #1; checks++;
    if (dbg_data !== 32'h0) begin fails++; $display("FAIL wrap_w1: got %h, want 0", dbg_data); end
    beat_data[0] = 32'h99;
    run_burst(32'h18, 8'd0, 3'b001, 2'b01, -1, 0, -1, r);
    checks++;
    if (timed_out || r !== 2'b10) begin
      fails++; $display("FAIL size_resp: got %b timeout=%0d, want 10", r, timed_out);
    end
    dbg_addr = 4'd6; #1; checks++;
    if (dbg_data !== 32'h0) begin fails++; $display("FAIL size_w6: got %h, want 0", dbg_data); end
  endtask

  task automatic test_wlast();
    timed_out = 1'b0;
    beat_strb = 4'hF;
    beat_data[0] = 32'h80; beat_data[1] = 32'h81;
    run_burst(32'h20, 8'd1, 3'b010, 2'b01, -1, 0, 0, r);
    checks++;
    if (timed_out || r !== 2'b10) begin
      fails++; $display("FAIL wlast_early_resp: got %b timeout=%0d, want 10", r, timed_out);
    end
    dbg_addr = 4'd8; #1; checks++;
    if (dbg_data !== 32'h80) begin fails++; $display("FAIL wlast_w8: got %h, want 80", dbg_data); end
    dbg_addr = 4'd9; #1; checks++;
    if (dbg_data !== 32'h81) begin fails++; $display("FAIL wlast_w9: got %h, want 81", dbg_data); end
    beat_data[0] = 32'hC0;
    run_burst(32'h30, 8'd0, 3'b010, 2'b01, -1, 0, 0, r);
    checks++;
    if (timed_out || r !== 2'b10) begin
      fails++; $display("FAIL wlast_missing_resp: got %b timeout=%0d, want 10", r, timed_out);
    end
    dbg_addr = 4'd12; #1; checks++;
    if (dbg_data !== 32'hC0) begin fails++; $display("FAIL wlast_w12: got %h, want c0", dbg_data); end
  endtask

  task automatic test_fixed();
    timed_out = 1'b0;
    beat_strb = 4'hF;
    beat_data[0] = 32'h11; beat_data[1] = 32'h22; beat_data[2] = 32'h33;
    run_burst(32'h28, 8'd2, 3'b010, 2'b00, -1, 0, -1, r);
    checks++;
    if (timed_out || r !== 2'b00) begin
      fails++; $display("FAIL fixed_resp: got %b timeout=%0d, want 00", r, timed_out);
    end
    dbg_addr = 4'd10; #1; checks++;
    if (dbg_data !== 32'h33) begin fails++; $display("FAIL fixed_w10: got %h, want 33", dbg_data); end
    dbg_addr = 4'd11; #1; checks++;
    if (dbg_data !== 32'h0) begin fails++; $display("FAIL fixed_w11: got %h, want 0", dbg_data); end
  endtask

  task automatic test_strobe();
    logic [31:0] want;
`ifdef AXI4_S_WRITE_WSTRB_EN
    want = 32'hFF00_FF00;
`else
    want = 32'h0000_0000;
`endif
    timed_out = 1'b0;
    beat_strb = 4'b0101;
    beat_data[0] = 32'h0;
    run_burst(32'h0, 8'd0, 3'b010, 2'b00, -1, 0, -1, r);
    beat_strb = 4'hF;
    checks++;
    if (timed_out || r !== 2'b00) begin
      fails++; $display("FAIL strobe_resp: got %b timeout=%0d, want 00", r, timed_out);
    end
    dbg_addr = 4'd0; #1; checks++;
    if (dbg_data !== want) begin fails++; $display("FAIL strobe_w0: got %h, want %h", dbg_data, want); end
  endtask

  task automatic test_len255();
    timed_out = 1'b0;
    beat_strb = 4'hF;
    for (int i = 0; i < 256; i++) beat_data[i] = 32'(i + 'h100);
    run_burst(32'hC, 8'd255, 3'b010, 2'b00, -1, 0, -1, r);
    checks++;
    if (timed_out || r !== 2'b00) begin
      fails++; $display("FAIL len255_resp: got %b timeout=%0d, want 00", r, timed_out);
    end
    dbg_addr = 4'd3; #1; checks++;
    if (dbg_data !== 32'h1FF) begin fails++; $display("FAIL len255_w3: got %h, want 1ff", dbg_data); end
  endtask

  task automatic test_bready_hold_reset();
    logic bad;
    tick();
    axi.s_axi_awaddr = 32'h34; axi.s_axi_awlen = 8'd0; axi.s_axi_awsize = 3'b010;
    axi.s_axi_awburst = 2'b01; axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = 32'hCAFE; axi.s_axi_wstrb = 4'hF;
    axi.s_axi_wlast = 1'b1;
    tick();
    axi.s_axi_awvalid = 1'b0;
    tick();
    axi.s_axi_wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({axi.s_axi_bvalid, axi.s_axi_bresp} !== 3'b100) begin
        fails++; $display("FAIL bhold_cycle%0d: got bvalid/bresp=%b, want 100", c,
                          {axi.s_axi_bvalid, axi.s_axi_bresp});
      end
      tick();
    end
    axi.s_axi_bready = 1'b1;
    tick();
    axi.s_axi_bready = 1'b0;
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_bvalid} !== 2'b10) begin
      fails++; $display("FAIL bhold_release: got awready/bvalid=%b, want 10",
                        {axi.s_axi_awready, axi.s_axi_bvalid});
    end
    dbg_addr = 4'd13; #1; checks++;
    if (dbg_data !== 32'hCAFE) begin fails++; $display("FAIL bhold_w13: got %h, want cafe", dbg_data); end
    // Abandon a burst after two of four beats.
    tick();
    axi.s_axi_awaddr = 32'h0; axi.s_axi_awlen = 8'd3; axi.s_axi_awvalid = 1'b1;
    tick();
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid = 1'b1; axi.s_axi_wlast = 1'b0; axi.s_axi_wdata = 32'h1;
    tick();
    axi.s_axi_wdata = 32'h2;
    tick();
    axi.s_axi_wvalid = 1'b0;
    areset = 1'b1;
    tick();
    checks++;
    if ({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_bresp} !== 5'b0) begin
      fails++; $display("FAIL midreset_outputs: got %b, want 00000",
                        {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_bresp});
    end
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      dbg_addr = 4'(k); #1;
      if (dbg_data !== 32'h0) bad = 1'b1;
    end
    checks++;
    if (bad) begin fails++; $display("FAIL midreset_mem: got nonzero word, want all 0"); end
    tick();
    axi.s_axi_awaddr = 32'h4; axi.s_axi_awlen = 8'd0; axi.s_axi_awvalid = 1'b1;
    areset = 1'b0;
    #1;
    checks++;
    if (axi.s_axi_awready !== 1'b1) begin
      fails++; $display("FAIL midreset_awready: got %b, want 1", axi.s_axi_awready);
    end
    tick();
    axi.s_axi_awvalid = 1'b0;
    checks++;
    if (axi.s_axi_wready !== 1'b1) begin
      fails++; $display("FAIL midreset_wready: got %b, want 1", axi.s_axi_wready);
    end
    axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = 32'h77; axi.s_axi_wlast = 1'b1;
    tick();
    axi.s_axi_wvalid = 1'b0;
    checks++;
    if ({axi.s_axi_bvalid, axi.s_axi_bresp} !== 3'b100) begin
      fails++; $display("FAIL midreset_resp: got bvalid/bresp=%b, want 100",
                        {axi.s_axi_bvalid, axi.s_axi_bresp});
    end
    axi.s_axi_bready = 1'b1;
    tick();
    axi.s_axi_bready = 1'b0;
    dbg_addr = 4'd1; #1; checks++;
    if (dbg_data !== 32'h77) begin fails++; $display("FAIL midreset_w1: got %h, want 77", dbg_data); end
    dbg_addr = 4'd0; #1; checks++;
    if (dbg_data !== 32'h0) begin fails++; $display("FAIL midreset_w0: got %h, want 0", dbg_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_gap();
    test_decerr();
    test_unsupported();
    test_wlast();
    test_fixed();
    test_strobe();
    test_len255();
    test_bready_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
